// File: rtl/ica_pkg.sv
// Shared definitions for the ICA decorrelation datapath: Q12.13 widths,
// the control state encoding and the saturating accumulator narrow.
package ica_pkg;

  localparam int DATA_W = 26;
  localparam int FRAC_W = 13;
  localparam int ACC_W  = 54;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Drops the fraction (arithmetic shift, floor) and clamps to DATA_W.
  function automatic logic [DATA_W-1:0] sat_narrow(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_W;
    if (sh > ACC_SAT_MAX)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (sh < ACC_SAT_MIN)
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return sh[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/mac_sat26.sv
// Single registered signed multiply-accumulate; clr restarts the sum with this
// cycle's product, sat_o is the narrowed value of the sum being registered.
module mac_sat26
  import ica_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic        [DATA_W-1:0] sat_o
);

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_nxt;

  always_comb begin
    prod     = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) *
               $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    acc_nxt  = (clr_i ? '0 : acc_q) + prod_ext;
    acc_d    = en_i ? acc_nxt : acc_q;
    sat_o    = sat_narrow(acc_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/symm_apply4.sv
// Computes O = A*W for 4x4 Q13 matrices with one shared MAC over 64 cycles;
// start is only accepted while idle, done pulses once per completed product.
module symm_apply4
  import ica_pkg::*;
(
  input  logic              clk_app4,
  input  logic              rstn_app4,
  input  logic              start_app4,
  input  logic [DATA_W-1:0] a11, a12, a13, a14,
  input  logic [DATA_W-1:0] a21, a22, a23, a24,
  input  logic [DATA_W-1:0] a31, a32, a33, a34,
  input  logic [DATA_W-1:0] a41, a42, a43, a44,
  input  logic [DATA_W-1:0] w11, w12, w13, w14,
  input  logic [DATA_W-1:0] w21, w22, w23, w24,
  input  logic [DATA_W-1:0] w31, w32, w33, w34,
  input  logic [DATA_W-1:0] w41, w42, w43, w44,
  output logic              busy_app4,
  output logic              done_app4,
  output logic [DATA_W-1:0] o11, o12, o13, o14,
  output logic [DATA_W-1:0] o21, o22, o23, o24,
  output logic [DATA_W-1:0] o31, o32, o33, o34,
  output logic [DATA_W-1:0] o41, o42, o43, o44
);

  state_t state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [3:0][3:0][DATA_W-1:0] a_in, w_in;
  logic [3:0][3:0][DATA_W-1:0] a_q, a_d, w_q, w_d, o_q, o_d;
  logic [1:0] r, c, k;
  logic              mac_en, mac_clr;
  logic [DATA_W-1:0] mac_a, mac_b, mac_sat;

  assign a_in[0][0] = a11; assign a_in[0][1] = a12; assign a_in[0][2] = a13; assign a_in[0][3] = a14;
  assign a_in[1][0] = a21; assign a_in[1][1] = a22; assign a_in[1][2] = a23; assign a_in[1][3] = a24;
  assign a_in[2][0] = a31; assign a_in[2][1] = a32; assign a_in[2][2] = a33; assign a_in[2][3] = a34;
  assign a_in[3][0] = a41; assign a_in[3][1] = a42; assign a_in[3][2] = a43; assign a_in[3][3] = a44;
  assign w_in[0][0] = w11; assign w_in[0][1] = w12; assign w_in[0][2] = w13; assign w_in[0][3] = w14;
  assign w_in[1][0] = w21; assign w_in[1][1] = w22; assign w_in[1][2] = w23; assign w_in[1][3] = w24;
  assign w_in[2][0] = w31; assign w_in[2][1] = w32; assign w_in[2][2] = w33; assign w_in[2][3] = w34;
  assign w_in[3][0] = w41; assign w_in[3][1] = w42; assign w_in[3][2] = w43; assign w_in[3][3] = w44;

  assign o11 = o_q[0][0]; assign o12 = o_q[0][1]; assign o13 = o_q[0][2]; assign o14 = o_q[0][3];
  assign o21 = o_q[1][0]; assign o22 = o_q[1][1]; assign o23 = o_q[1][2]; assign o24 = o_q[1][3];
  assign o31 = o_q[2][0]; assign o32 = o_q[2][1]; assign o33 = o_q[2][2]; assign o34 = o_q[2][3];
  assign o41 = o_q[3][0]; assign o42 = o_q[3][1]; assign o43 = o_q[3][2]; assign o44 = o_q[3][3];

  assign busy_app4 = busy_q;
  assign done_app4 = done_q;

  always_ff @(posedge clk_app4 or negedge rstn_app4) begin
    if (!rstn_app4) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_app4) state_d = RUN;
      RUN:     if (idx_q == 6'd63) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered, so they trail the state by one cycle.
  always_comb begin
    busy_d = (state_q != IDLE);
    done_d = (state_q == DONE);
  end

  assign r = idx_q[5:4];
  assign c = idx_q[3:2];
  assign k = idx_q[1:0];

  assign mac_en  = (state_q == RUN);
  assign mac_clr = (k == 2'd0);
  assign mac_a   = a_q[r][k];
  assign mac_b   = w_q[k][c];

  mac_sat26 u_mac (
    .clk   (clk_app4),
    .rst_n (rstn_app4),
    .en_i  (mac_en),
    .clr_i (mac_clr),
    .a_i   (mac_a),
    .b_i   (mac_b),
    .sat_o (mac_sat)
  );

  always_comb begin
    a_d   = a_q;
    w_d   = w_q;
    o_d   = o_q;
    idx_d = idx_q;
    if (state_q == IDLE && start_app4) begin
      a_d   = a_in;
      w_d   = w_in;
      idx_d = '0;
    end
    if (state_q == RUN) begin
      idx_d = idx_q + 6'd1;
      if (k == 2'd3) o_d[r][c] = mac_sat;
    end
  end

  always_ff @(posedge clk_app4 or negedge rstn_app4) begin
    if (!rstn_app4) begin
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      a_q    <= '0;
      w_q    <= '0;
      o_q    <= '0;
    end else begin
      idx_q  <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      a_q    <= a_d;
      w_q    <= w_d;
      o_q    <= o_d;
    end
  end

endmodule

// File: tb/tb_symm_apply4.sv
// Randomized scoreboard bench for symm_apply4: expected O = A*W sets are queued
// at issue time and checked by a monitor on every done pulse.
module tb_symm_apply4;

  typedef logic [16*26-1:0] flat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic signed [25:0] a_m [4][4];
  logic signed [25:0] w_m [4][4];
  logic signed [25:0] o_m [4][4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0;
  logic prev_done = 1'b0;
  flat_t exp_q[$];
  int    edge_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  symm_apply4 dut (
    .clk_app4(clk), .rstn_app4(rstn), .start_app4(start),
    .a11(a_m[0][0]), .a12(a_m[0][1]), .a13(a_m[0][2]), .a14(a_m[0][3]),
    .a21(a_m[1][0]), .a22(a_m[1][1]), .a23(a_m[1][2]), .a24(a_m[1][3]),
    .a31(a_m[2][0]), .a32(a_m[2][1]), .a33(a_m[2][2]), .a34(a_m[2][3]),
    .a41(a_m[3][0]), .a42(a_m[3][1]), .a43(a_m[3][2]), .a44(a_m[3][3]),
    .w11(w_m[0][0]), .w12(w_m[0][1]), .w13(w_m[0][2]), .w14(w_m[0][3]),
    .w21(w_m[1][0]), .w22(w_m[1][1]), .w23(w_m[1][2]), .w24(w_m[1][3]),
    .w31(w_m[2][0]), .w32(w_m[2][1]), .w33(w_m[2][2]), .w34(w_m[2][3]),
    .w41(w_m[3][0]), .w42(w_m[3][1]), .w43(w_m[3][2]), .w44(w_m[3][3]),
    .busy_app4(busy), .done_app4(done),
    .o11(o_m[0][0]), .o12(o_m[0][1]), .o13(o_m[0][2]), .o14(o_m[0][3]),
    .o21(o_m[1][0]), .o22(o_m[1][1]), .o23(o_m[1][2]), .o24(o_m[1][3]),
    .o31(o_m[2][0]), .o32(o_m[2][1]), .o33(o_m[2][2]), .o34(o_m[2][3]),
    .o41(o_m[3][0]), .o42(o_m[3][1]), .o43(o_m[3][2]), .o44(o_m[3][3])
  );

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: integer matrix product, floor-divide by 2^13, clamp to 26 bits.
  function automatic flat_t model();
    flat_t res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        longint s = 0;
        for (int k = 0; k < 4; k++)
          s += longint'(a_m[r][k]) * longint'(w_m[k][c]);
        s = s >>> 13;
        if (s > 33554431) s = 33554431;
        if (s < -33554432) s = -33554432;
        res[(r*4+c)*26 +: 26] = s[25:0];
      end
    return res;
  endfunction

  function automatic int rnd(int mag);
    return int'($urandom_range(0, 2*mag)) - mag;
  endfunction

  task automatic rand_mats(input int amag, input int wmag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = 26'(rnd(amag));
        w_m[i][j] = 26'(rnd(wmag));
      end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn && done) begin
      n_done++;
      chk("done_single_pulse", longint'(prev_done), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        flat_t e;
        int    ed;
        e  = exp_q.pop_front();
        ed = edge_q.pop_front();
        chk("done_latency", cyc - ed, 65);
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            chk($sformatf("o%0d%0d", r+1, c+1), longint'(o_m[r][c]),
                longint'($signed(e[(r*4+c)*26 +: 26])));
      end
    end
    prev_done = rstn && done;
  end

  // Issues one op from a_m/w_m; returns 1 edge after capture (idx=1 running).
  task automatic issue();
    exp_q.push_back(model());
    start = 1'b1;
    @(posedge clk); #1;
    edge_q.push_back(cyc);
    start = 1'b0;
    chk("busy_at_capture", longint'(busy), 0);
    @(posedge clk); #1;
    chk("busy_after_capture", longint'(busy), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("done_timeout", 1, 0);
    @(posedge clk); #1;
    chk("busy_after_done", longint'(busy), 0);
  endtask

  initial begin
    int nd;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = '0;
        w_m[i][j] = '0;
      end
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk("reset_o", longint'(o_m[r][c]), 0);

    // T1 identity
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = (i == j) ? 26'sd8192 : 26'sd0;
        w_m[i][j] = 26'(((i*4 + j) + 1) * 8192);
      end
    issue();
    wait_done();

    // T2 scale by 2, several random W
    for (int t = 0; t < 3; t++) begin
      rand_mats(0, 1 << 20);
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          a_m[i][j] = (i == j) ? 26'sd16384 : 26'sd0;
      issue();
      wait_done();
    end

    // T3 saturation, positive then negative
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          a_m[i][j] = 26'sd32768;
          w_m[i][j] = (s == 0) ? 26'sd16777216 : -26'sd16777216;
        end
      issue();
      wait_done();
    end

    // Fully random operands, including clamping cases
    for (int t = 0; t < 3; t++) begin
      rand_mats(1 << 24, 1 << 24);
      issue();
      wait_done();
    end

    // T4 start during RUN is ignored
    rand_mats(1 << 18, 1 << 18);
    nd = n_done;
    issue();
    repeat (9) @(posedge clk);
    #1;
    rand_mats(1 << 18, 1 << 18);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (70) @(posedge clk);
    #1;
    chk("t4_one_done", n_done - nd, 1);

    // T5 reset mid-op
    rand_mats(1 << 18, 1 << 18);
    issue();
    repeat (29) @(posedge clk);
    #1;
    nd = n_done;
    rstn = 1'b0;
    exp_q.delete();
    edge_q.delete();
    #1;
    chk("t5_busy", longint'(busy), 0);
    chk("t5_done", longint'(done), 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk("t5_o_clear", longint'(o_m[r][c]), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("t5_no_done", n_done - nd, 0);
    rand_mats(1 << 20, 1 << 20);
    issue();
    wait_done();

    // T6 start held high for three back-to-back ops
    nd = n_done;
    rand_mats(1 << 20, 1 << 20);
    exp_q.push_back(model());
    start = 1'b1;
    @(posedge clk); #1;
    edge_q.push_back(cyc);
    for (int op = 1; op < 3; op++) begin
      rand_mats(1 << 20, 1 << 20);
      exp_q.push_back(model());
      repeat (66) @(posedge clk);
      #1;
      edge_q.push_back(cyc);
    end
    start = 1'b0;
    wait_done();
    repeat (70) @(posedge clk);
    #1;
    chk("t6_three_dones", n_done - nd, 3);
    chk("pending_expectations", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
